ctrl_buffer_enteros: RTL and testbench
======================================

# ctrl_buffer_enteros

Sequencing controller for the integer-pixel row buffer (`buffer_enteros`) in the FME datapath. It runs one block per `inicio` request: it loads `width_fil` rows from the integer search-window source into the buffer, then streams them out, in the same order, to the interpolation stage. It drives the buffer's `wr`/`en` controls and brackets the block with busy and done indications. It does not touch pixel data; `fila_in`/`fila_out` connect directly between source, buffer and sink.

## Interface
- `width_fil`, 16: rows per block (≥2).
- `cnt_w`, `$clog2(width_fil)`: width of the row counter.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `inicio`  in  1  start request; sampled only in REPOSO.
- `cancelar`  in  1  synchronous abort; returns to REPOSO next edge, no `fin`.
- `fila_val`  in  1  source row valid.
- `fila_rdy`  out  1  controller accepts a source row (state CARGA).
- `sal_rdy`  in  1  sink ready for a buffer row.
- `sal_val`  out  1  buffer head row valid for the sink (state LECTURA).
- `buf_wr`  out  1  to buffer `wr`: 0 = write, 1 = read.
- `buf_en`  out  1  to buffer `en`: advances the buffer one row.
- `fila_cnt`  out  cnt_w  index of the row currently being written or read.
- `ocupado`  out  1  high in CARGA, LECTURA and FIN.
- `fin`  out  1  one-cycle pulse, block complete.

## Operation
- Buffer contract: on a rising edge with `en`=1, `wr`=0 shifts `fila_in` in; `wr`=1 advances the read pointer. `fila_out` is the current head row, combinational. After `width_fil` reads the buffer is logically empty.
- States (2-bit, registered): REPOSO=0, CARGA=1, LECTURA=2, FIN=3.
- REPOSO: `inicio`=1 → CARGA, `fila_cnt`←0.
- CARGA: `fila_rdy`=1, `buf_wr`=0, `buf_en`=`fila_val`. Each accepted row does `fila_cnt`++. On acceptance with `fila_cnt`=width_fil-1 → LECTURA, `fila_cnt`←0.
- LECTURA: `sal_val`=1, `buf_wr`=1, `buf_en`=`sal_rdy` (see Configuration). Each transfer does `fila_cnt`++. A transfer with `fila_cnt`=width_fil-1 → FIN.
- FIN: `fin`=1 for this cycle only. Next edge → REPOSO, `fila_cnt`←0.
- `buf_wr` is 0 in REPOSO and FIN. `buf_en` is 0 outside CARGA and LECTURA.
- `inicio` is ignored outside REPOSO. No queueing.
- `cancelar` has priority over every transition, including the last-row transfer: next state REPOSO, `fila_cnt`←0, no `fin`. A row accepted on the cancel edge still enters the buffer. The buffer contents are then stale; the next block overwrites them in full.
- `fila_cnt` wraps only via the explicit reset-to-0 at the last row, never by overflow.

## Timing
- Reset values: state REPOSO; `fila_cnt`=0; `fila_rdy`, `sal_val`, `buf_wr`, `buf_en`, `ocupado`, `fin` all 0.
- Asserting `rst` mid-block aborts immediately, asynchronously. Same outputs as reset; no `fin`.
- `fila_rdy`, `sal_val`, `ocupado`, `fin`, `buf_wr` are Moore outputs decoded from state. `buf_en` is combinational from state plus `fila_val`/`sal_rdy`.
- Minimum latency, `inicio` edge to `fin` high, with `fila_val`=`sal_rdy`=1 throughout: 2·width_fil+1 cycles (33 at default). `ocupado` is high for 2·width_fil+1 cycles.
- Stalls extend CARGA/LECTURA one cycle per idle cycle. Nothing is lost or duplicated.
- `inicio` held high across FIN starts a new block the cycle after REPOSO is entered.

## Configuration
- `CTRL_BE_BACKPRESSURE_EN` defined: LECTURA advances only when `sal_rdy`=1 (`buf_en`=`sal_rdy`).
- Undefined: `sal_rdy` is ignored. LECTURA transfers every cycle (`buf_en`=1), and LECTURA always lasts exactly width_fil cycles.

## Test plan
- Reset, then `inicio` pulse with 16 rows, each byte = row index (0x00..0x0F), `fila_val`=1, `sal_rdy`=1 → sink sees rows 0x00..0x0F in order, `fin` exactly 33 cycles after the `inicio` edge, `ocupado` low afterwards.
- Source gaps: `fila_val` low on every odd cycle → 16 writes over 31 cycles, `fila_cnt` reaches 15 before LECTURA, output data unchanged.
- Macro defined, `sal_rdy` low for 3 cycles at row 5 → `buf_en`=0 and `fila_cnt`=5 held during the stall, row 0x05 presented throughout, no duplicated or missing rows.
- Macro undefined, same `sal_rdy` pattern → LECTURA lasts exactly 16 cycles regardless.
- `cancelar` at `fila_cnt`=7 in CARGA → REPOSO next cycle, no `fin`; a following full block returns its own 16 rows correctly.
- `rst` low mid-LECTURA, then `inicio` held high while in CARGA → all outputs 0 immediately on reset; `inicio` ignored while in CARGA; the next block after reset completes with `fin` at 33 cycles.

Source files
------------

// File: rtl/ctrl_buffer_enteros.sv
// Sequencing controller for the integer-pixel row buffer: loads width_fil rows, then streams them out.
// Optional sink backpressure in LECTURA is enabled by defining CTRL_BE_BACKPRESSURE_EN.
module ctrl_buffer_enteros #(
   parameter int width_fil = 16,
   parameter int cnt_w     = $clog2(width_fil)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inicio_i,
   input  logic             cancelar_i,
   input  logic             fila_val_i,
   output logic             fila_rdy_o,
   input  logic             sal_rdy_i,
   output logic             sal_val_o,
   output logic             buf_wr_o,
   output logic             buf_en_o,
   output logic [cnt_w-1:0] fila_cnt_o,
   output logic             ocupado_o,
   output logic             fin_o
);

   typedef enum logic [1:0] {
      REPOSO  = 2'd0,
      CARGA   = 2'd1,
      LECTURA = 2'd2,
      FIN     = 2'd3
   } state_t;

   localparam logic [cnt_w-1:0] LastRow = cnt_w'(width_fil - 1);

   state_t           state_q, state_d;
   logic [cnt_w-1:0] cnt_q, cnt_d;
   logic             lastRow;
   logic             salAdvance;

   assign lastRow = (cnt_q == LastRow);

`ifdef CTRL_BE_BACKPRESSURE_EN
   assign salAdvance = sal_rdy_i;
`else
   // Without backpressure the sink is assumed always ready.
   logic unusedSalRdy;
   assign unusedSalRdy = sal_rdy_i;
   assign salAdvance   = 1'b1;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= REPOSO;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      fila_rdy_o = 1'b0;
      sal_val_o  = 1'b0;
      buf_wr_o   = 1'b0;
      buf_en_o   = 1'b0;
      ocupado_o  = 1'b0;
      fin_o      = 1'b0;

      case (state_q)
         REPOSO: begin
            if (inicio_i) begin
               state_d = CARGA;
               cnt_d   = '0;
            end
         end
         CARGA: begin
            fila_rdy_o = 1'b1;
            ocupado_o  = 1'b1;
            buf_en_o   = fila_val_i;
            if (fila_val_i) begin
               if (lastRow) begin
                  state_d = LECTURA;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + cnt_w'(1);
               end
            end
         end
         LECTURA: begin
            sal_val_o = 1'b1;
            buf_wr_o  = 1'b1;
            ocupado_o = 1'b1;
            buf_en_o  = salAdvance;
            if (salAdvance) begin
               if (lastRow) begin
                  state_d = FIN;
               end else begin
                  cnt_d = cnt_q + cnt_w'(1);
               end
            end
         end
         FIN: begin
            fin_o     = 1'b1;
            ocupado_o = 1'b1;
            state_d   = REPOSO;
            cnt_d     = '0;
         end
         default: begin
            state_d = REPOSO;
            cnt_d   = '0;
         end
      endcase

      // Abort wins over every transition, even the last-row transfer.
      if (cancelar_i) begin
         state_d = REPOSO;
         cnt_d   = '0;
      end
   end

   assign fila_cnt_o = cnt_q;

endmodule

// File: tb/tb_ctrl_buffer_enteros.sv
// Self-checking bench for ctrl_buffer_enteros; models the row buffer and scoreboards sink rows.
// Stall expectations follow CTRL_BE_BACKPRESSURE_EN.
module tb_ctrl_buffer_enteros;

   localparam int widthFil = 16;
   localparam int cntW     = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rstN, inicio, cancelar, filaVal, salRdy;
   logic            filaRdy, salVal, bufWr, bufEn, ocupado, fin;
   logic [cntW-1:0] filaCnt;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] bufQ[$];
   logic [7:0] expQ[$];
   logic [7:0] srcRow = 8'h00;
   int         readCnt, writeCnt, ocupadoCnt, lectCnt, cargaCnt, finCnt, maxCargaCnt;

   ctrl_buffer_enteros #(.width_fil(widthFil), .cnt_w(cntW)) dut (
      .clk_i      (clk),
      .rst_ni     (rstN),
      .inicio_i   (inicio),
      .cancelar_i (cancelar),
      .fila_val_i (filaVal),
      .fila_rdy_o (filaRdy),
      .sal_rdy_i  (salRdy),
      .sal_val_o  (salVal),
      .buf_wr_o   (bufWr),
      .buf_en_o   (bufEn),
      .fila_cnt_o (filaCnt),
      .ocupado_o  (ocupado),
      .fin_o      (fin)
   );

   // Buffer model plus sink scoreboard; sampled mid-cycle, describing the coming rising edge.
   always @(negedge clk) begin
      logic [7:0] got, want;
      if (rstN === 1'b1) begin
         if (bufEn && !bufWr) begin
            bufQ.push_back(srcRow);
            writeCnt++;
         end
         if (filaVal && filaRdy) srcRow++;
         if (bufEn && bufWr) begin
            readCnt++;
            total++;
            if (bufQ.size() == 0) begin
               bad++;
               $display("[TB] FAIL sink_row: buffer read while empty, got none want a row");
            end else if (expQ.size() == 0) begin
               got = bufQ.pop_front();
               bad++;
               $display("[TB] FAIL sink_row: got %02h want no more rows", got);
            end else begin
               got  = bufQ.pop_front();
               want = expQ.pop_front();
               if (got !== want) begin
                  bad++;
                  $display("[TB] FAIL sink_row: got %02h want %02h", got, want);
               end
            end
         end
         if (ocupado) ocupadoCnt++;
         if (salVal) lectCnt++;
         if (filaRdy) begin
            cargaCnt++;
            if (int'(filaCnt) > maxCargaCnt) maxCargaCnt = int'(filaCnt);
         end
         if (fin) finCnt++;
      end
   end

   task tick;
      @(posedge clk);
      #1;
   endtask

   task armBlock(input logic [7:0] base);
      bufQ.delete();
      expQ.delete();
      srcRow = base;
      for (int i = 0; i < widthFil; i++) expQ.push_back(base + 8'(i));
      readCnt = 0; writeCnt = 0; ocupadoCnt = 0; lectCnt = 0;
      cargaCnt = 0; finCnt = 0; maxCargaCnt = 0;
   endtask

   task test_reset;
      rstN = 1'b0; inicio = 1'b0; cancelar = 1'b0; filaVal = 1'b0; salRdy = 1'b0;
      #3;
      total++;
      if ({filaRdy, salVal, bufWr, bufEn, ocupado, fin} !== 6'b0) begin
         bad++;
         $display("[TB] FAIL reset_outputs: got %b want 000000", {filaRdy, salVal, bufWr, bufEn, ocupado, fin});
      end
      total++;
      if (filaCnt !== 4'd0) begin
         bad++;
         $display("[TB] FAIL reset_cnt: got %0d want 0", filaCnt);
      end
      @(negedge clk);
      rstN = 1'b1;
      tick;
      total++;
      if (ocupado !== 1'b0 || filaRdy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL idle_after_reset: got ocupado=%b rdy=%b want 0 0", ocupado, filaRdy);
      end
   endtask

   task test_basic;
      int  n;
      bit  done;
      armBlock(8'h00);
      filaVal = 1'b1; salRdy = 1'b1; inicio = 1'b1;
      n = 0; done = 0;
      while (!done && n < 200) begin
         tick; n++;
         if (n == 1) inicio = 1'b0;
         if (fin === 1'b1) done = 1;
      end
      total++;
      if (!done || n != 33) begin
         bad++;
         $display("[TB] FAIL basic_latency: got %0d done=%0d want 33", n, done);
      end
      total++;
      if (readCnt != 16 || expQ.size() != 0) begin
         bad++;
         $display("[TB] FAIL basic_rows: got reads=%0d left=%0d want 16 0", readCnt, expQ.size());
      end
      tick;
      total++;
      if (ocupadoCnt != 33) begin
         bad++;
         $display("[TB] FAIL basic_ocupado_len: got %0d want 33", ocupadoCnt);
      end
      total++;
      if (ocupado !== 1'b0 || fin !== 1'b0 || finCnt != 1) begin
         bad++;
         $display("[TB] FAIL basic_after: got ocupado=%b fin=%b pulses=%0d want 0 0 1", ocupado, fin, finCnt);
      end
   endtask

   task test_source_gaps;
      int n;
      bit done;
      armBlock(8'h10);
      salRdy = 1'b1; inicio = 1'b1; filaVal = 1'b0;
      n = 0; done = 0;
      while (!done && n < 200) begin
         tick; n++;
         if (n == 1) inicio = 1'b0;
         filaVal = (n % 2 == 1);
         if (fin === 1'b1) done = 1;
      end
      total++;
      if (writeCnt != 16 || cargaCnt != 31) begin
         bad++;
         $display("[TB] FAIL gaps_carga: got writes=%0d cycles=%0d want 16 31", writeCnt, cargaCnt);
      end
      total++;
      if (maxCargaCnt != 15) begin
         bad++;
         $display("[TB] FAIL gaps_cnt_max: got %0d want 15", maxCargaCnt);
      end
      total++;
      if (!done || n != 48 || readCnt != 16 || expQ.size() != 0) begin
         bad++;
         $display("[TB] FAIL gaps_block: got lat=%0d reads=%0d left=%0d want 48 16 0", n, readCnt, expQ.size());
      end
      filaVal = 1'b1;
      tick;
   endtask

   task test_stall;
      int n, stallLeft, wantLat, wantLect;
      bit done, stalled;
`ifdef CTRL_BE_BACKPRESSURE_EN
      wantLat = 36; wantLect = 19;
`else
      wantLat = 33; wantLect = 16;
`endif
      armBlock(8'h20);
      filaVal = 1'b1; salRdy = 1'b1; inicio = 1'b1;
      n = 0; done = 0; stalled = 0; stallLeft = 0;
      while (!done && n < 200) begin
         tick; n++;
         if (n == 1) inicio = 1'b0;
         if (stallLeft > 0) stallLeft--;
         if (stallLeft == 0) salRdy = 1'b1;
         if (!stalled && salVal === 1'b1 && filaCnt == 4'd5) begin
            stalled = 1; stallLeft = 3; salRdy = 1'b0;
         end
         if (stallLeft > 0) begin
            #1;
`ifdef CTRL_BE_BACKPRESSURE_EN
            total++;
            if (bufEn !== 1'b0 || filaCnt !== 4'd5) begin
               bad++;
               $display("[TB] FAIL stall_hold: got en=%b cnt=%0d want 0 5", bufEn, filaCnt);
            end
            total++;
            if (bufQ.size() == 0 || bufQ[0] !== 8'h25) begin
               bad++;
               $display("[TB] FAIL stall_head: got size=%0d want head 25", bufQ.size());
            end
`else
            total++;
            if (bufEn !== 1'b1) begin
               bad++;
               $display("[TB] FAIL stall_ignored: got en=%b want 1", bufEn);
            end
`endif
         end
         if (fin === 1'b1) done = 1;
      end
      total++;
      if (!stalled) begin
         bad++;
         $display("[TB] FAIL stall_reached: got no row 5 in LECTURA want row 5");
      end
      total++;
      if (!done || n != wantLat || lectCnt != wantLect) begin
         bad++;
         $display("[TB] FAIL stall_len: got lat=%0d lect=%0d want %0d %0d", n, lectCnt, wantLat, wantLect);
      end
      total++;
      if (readCnt != 16 || expQ.size() != 0) begin
         bad++;
         $display("[TB] FAIL stall_rows: got reads=%0d left=%0d want 16 0", readCnt, expQ.size());
      end
      salRdy = 1'b1;
      tick;
   endtask

   task test_cancel;
      int n;
      bit hit, done;
      armBlock(8'h40);
      filaVal = 1'b1; salRdy = 1'b1; inicio = 1'b1;
      n = 0; hit = 0;
      while (!hit && n < 50) begin
         tick; n++;
         if (n == 1) inicio = 1'b0;
         if (filaRdy === 1'b1 && filaCnt == 4'd7) hit = 1;
      end
      cancelar = 1'b1;
      tick;
      cancelar = 1'b0;
      total++;
      if (!hit || ocupado !== 1'b0 || filaRdy !== 1'b0 || filaCnt !== 4'd0) begin
         bad++;
         $display("[TB] FAIL cancel_state: got hit=%0d ocupado=%b rdy=%b cnt=%0d want 1 0 0 0", hit, ocupado, filaRdy, filaCnt);
      end
      total++;
      if (writeCnt != 8) begin
         bad++;
         $display("[TB] FAIL cancel_writes: got %0d want 8", writeCnt);
      end
      repeat (5) tick;
      total++;
      if (finCnt != 0 || ocupado !== 1'b0) begin
         bad++;
         $display("[TB] FAIL cancel_no_fin: got pulses=%0d ocupado=%b want 0 0", finCnt, ocupado);
      end
      armBlock(8'h60);
      inicio = 1'b1;
      n = 0; done = 0;
      while (!done && n < 200) begin
         tick; n++;
         if (n == 1) inicio = 1'b0;
         if (fin === 1'b1) done = 1;
      end
      total++;
      if (!done || n != 33 || readCnt != 16 || expQ.size() != 0) begin
         bad++;
         $display("[TB] FAIL cancel_next_block: got lat=%0d reads=%0d left=%0d want 33 16 0", n, readCnt, expQ.size());
      end
      tick;
   endtask

   task test_reset_mid;
      int n;
      bit hit, done;
      armBlock(8'h80);
      filaVal = 1'b1; salRdy = 1'b1; inicio = 1'b1;
      n = 0; hit = 0;
      while (!hit && n < 100) begin
         tick; n++;
         if (n == 1) inicio = 1'b0;
         if (salVal === 1'b1 && filaCnt == 4'd3) hit = 1;
      end
      #1;
      rstN = 1'b0;
      #1;
      total++;
      if (!hit || {filaRdy, salVal, bufWr, bufEn, ocupado, fin} !== 6'b0 || filaCnt !== 4'd0) begin
         bad++;
         $display("[TB] FAIL reset_mid: got hit=%0d outs=%b cnt=%0d want 1 000000 0", hit, {filaRdy, salVal, bufWr, bufEn, ocupado, fin}, filaCnt);
      end
      @(negedge clk);
      rstN = 1'b1;
      tick;
      armBlock(8'hA0);
      inicio = 1'b1;
      n = 0; done = 0;
      while (!done && n < 200) begin
         tick; n++;
         if (n == 6) begin
            total++;
            if (filaRdy !== 1'b1 || filaCnt !== 4'd5) begin
               bad++;
               $display("[TB] FAIL inicio_ignored: got rdy=%b cnt=%0d want 1 5", filaRdy, filaCnt);
            end
            inicio = 1'b0;
         end
         if (fin === 1'b1) done = 1;
      end
      total++;
      if (!done || n != 33 || readCnt != 16 || expQ.size() != 0) begin
         bad++;
         $display("[TB] FAIL reset_next_block: got lat=%0d reads=%0d left=%0d want 33 16 0", n, readCnt, expQ.size());
      end
      tick;
   endtask

   initial begin
      test_reset;
      test_basic;
      test_source_gaps;
      test_stall;
      test_cancel;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
